mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter LOCK_LIMIT, default 255, the maximum cycles one owner may hold lock before forced release.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-high reset (1 = reset asserted).
REQ-004 SHALL have, per requester X in {f (fetch), e (execute), d (sprite DMA)}: X_req in 1, request; X_lock in 1, keep bus after this access; X_rw_n in 1, 1 = read / 0 = write; X_addr in 16, address; X_wdata in 8, write data.
REQ-005 SHALL have, per requester X, the outputs X_gnt out 1 (access accepted this cycle) and X_rvalid out 1 (rdata holds this requester's read data).
REQ-006 SHALL have port rdata, output, 8, shared read data equal to mem_rdata.
REQ-007 SHALL have the memory-side ports mem_en out 1, mem_rw_n out 1, mem_addr out 16, mem_wdata out 8 and mem_rdata in 8.
REQ-008 SHALL have port owner, output, 2, current bus owner: 0 none, 1 f, 2 e, 3 d.
REQ-009 SHALL have port lock_err, output, 1, sticky flag set on a forced lock release.

Function
REQ-010 SHALL arbitrate with fixed priority d > e > f over requests sampled at each rising edge.
REQ-011 SHALL register the winner's address, rw_n and wdata onto mem_addr, mem_rw_n and mem_wdata at the edge, with mem_en=1 and X_gnt=1 for exactly one cycle (cycle T).
REQ-012 SHALL take mem_rdata in cycle T+1 (one-cycle memory latency) and drive X_rvalid=1 in T+1 only when the access was a read; a write SHALL produce no rvalid.
REQ-013 SHALL allow a new grant in T+1 (one access per cycle sustained), with an rvalid for the previous access and a gnt for the new one in the same cycle.
REQ-014 SHALL require requesters to hold req, addr, rw_n and wdata stable until gnt; dropping req before gnt SHALL cancel the request with no bus activity.
REQ-015 SHALL use FSM states IDLE, OPEN and LOCKED.
- IDLE: no access this cycle, owner=0.
- OPEN: access issued without lock.
- LOCKED: the owner issued its last access with X_lock=1.
REQ-016 SHALL, in LOCKED, arbitrate only the locked owner; higher-priority requests wait, and the owner's accesses keep 1-per-cycle timing.
REQ-017 SHALL leave LOCKED for normal arbitration at the first edge where the owner presents req=1 with lock=0 (the final access is granted) or presents lock=0 with req=0 (release, no access).
REQ-018 SHALL count cycles spent in LOCKED with an 8-bit counter, clear it on entry to LOCKED, and saturate it.
REQ-019 SHALL, when the lock counter reaches LOCK_LIMIT, force a return to normal arbitration on the next edge and set lock_err=1; lock_err SHALL clear only on reset.
REQ-020 SHALL transition OPEN/LOCKED to IDLE when no request wins; owner SHALL reflect the requester granted in the current cycle, or the locked owner while in LOCKED.
REQ-021 SHALL treat simultaneous req from all three as a grant to d, with e and f held pending and unacknowledged.
REQ-022 SHALL make mem_addr a 16-bit pass-through with no arithmetic or wrap; 16'hFFFF is legal.
REQ-023 SHALL keep mem_rw_n=1 in any cycle with mem_en=0.

Reset
REQ-024 SHALL, while rst_n=1, asynchronously force all of the following, regardless of in-flight reads:
- every X_gnt, X_rvalid and mem_en to 0;
- mem_rw_n to 1; mem_addr, mem_wdata, owner and lock_err to 0;
- FSM to IDLE and the lock counter to 0.
REQ-025 SHALL NOT produce an rvalid after reset deassertion for any access issued before reset.
REQ-026 SHALL allow its first grant at the first rising edge after rst_n falls, provided a request is present.

Verification
REQ-027 Single read: f_req=1, f_addr=16'h8000, f_rw_n=1, mem_rdata=8'hA9 in T+1 -> f_gnt=1 in T with mem_addr=8000, then f_rvalid=1 and rdata=A9 in T+1, owner=1 in T.
REQ-028 Priority: f, e and d all request in the same cycle -> d_gnt first, then e_gnt, then f_gnt on consecutive cycles, with no idle cycle between them.
REQ-029 Lock: e issues three reads (addrs 0x0042, 0x0043, 0x1234) with lock=1,1,0 while d_req=1 -> all three e_gnt occur back-to-back and d_gnt occurs only in the cycle after the third.
REQ-030 Lock timeout: LOCK_LIMIT=4, e holds lock=1 with req=0 -> forced release after 4 cycles, lock_err=1 and a pending f request is granted next.
REQ-031 Write: d writes 8'h5C to 16'h2004 -> mem_rw_n=0, mem_wdata=5C in grant cycle and no d_rvalid follows.
REQ-032 Reset mid-read: assert rst_n in T+1 of an e read -> e_rvalid=0 immediately, all outputs at reset values, FSM IDLE, and no rvalid after release.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the three requesters (fetch, execute, sprite DMA), the
// memory port and the arbiter. The arbiter uses slave; requesters and memory use master.
interface mem_bus_arbiter_if;
    logic        f_req;
    logic        f_lock;
    logic        f_rw_n;
    logic [15:0] f_addr;
    logic [7:0]  f_wdata;
    logic        f_gnt;
    logic        f_rvalid;

    logic        e_req;
    logic        e_lock;
    logic        e_rw_n;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;
    logic        e_gnt;
    logic        e_rvalid;

    logic        d_req;
    logic        d_lock;
    logic        d_rw_n;
    logic [15:0] d_addr;
    logic [7:0]  d_wdata;
    logic        d_gnt;
    logic        d_rvalid;

    logic [7:0]  rdata;
    logic        mem_en;
    logic        mem_rw_n;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [1:0]  owner;
    logic        lock_err;

    modport slave (
        input  f_req, f_lock, f_rw_n, f_addr, f_wdata,
        input  e_req, e_lock, e_rw_n, e_addr, e_wdata,
        input  d_req, d_lock, d_rw_n, d_addr, d_wdata,
        input  mem_rdata,
        output f_gnt, f_rvalid, e_gnt, e_rvalid, d_gnt, d_rvalid,
        output rdata, mem_en, mem_rw_n, mem_addr, mem_wdata, owner, lock_err
    );

    modport master (
        output f_req, f_lock, f_rw_n, f_addr, f_wdata,
        output e_req, e_lock, e_rw_n, e_addr, e_wdata,
        output d_req, d_lock, d_rw_n, d_addr, d_wdata,
        output mem_rdata,
        input  f_gnt, f_rvalid, e_gnt, e_rvalid, d_gnt, d_rvalid,
        input  rdata, mem_en, mem_rw_n, mem_addr, mem_wdata, owner, lock_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority (d > e > f) single-port memory arbiter with bus locking,
// one access per cycle, one-cycle read latency and a lock-hold watchdog.
module mem_bus_arbiter #(
    parameter int LOCK_LIMIT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        LOCKED
    } state_t;

    localparam logic [7:0] LIMIT8 = 8'(LOCK_LIMIT);

    state_t      state;
    logic [1:0]  owner_q;
    logic [7:0]  lock_cnt;
    logic [3:1]  gnt_q;
    logic [3:1]  rvalid_q;
    logic        mem_en_q;
    logic        mem_rw_n_q;
    logic [15:0] mem_addr_q;
    logic [7:0]  mem_wdata_q;
    logic        lock_err_q;

    logic [3:0]  req;
    logic [3:0]  lock;
    logic [3:0]  rw_n;
    logic [15:0] addr [4];
    logic [7:0]  wdata [4];

    logic        forced;
    logic        hold_bus;
    logic [1:0]  winner;
    logic [3:1]  gnt_next;
    logic [7:0]  cnt_inc;

    // Requester index matches the owner encoding (1 f, 2 e, 3 d); slot 0 is "nobody".
    always_comb begin
        req      = {bus.d_req,  bus.e_req,  bus.f_req,  1'b0};
        lock     = {bus.d_lock, bus.e_lock, bus.f_lock, 1'b0};
        rw_n     = {bus.d_rw_n, bus.e_rw_n, bus.f_rw_n, 1'b1};
        addr[0]  = 16'h0000;
        addr[1]  = bus.f_addr;
        addr[2]  = bus.e_addr;
        addr[3]  = bus.d_addr;
        wdata[0] = 8'h00;
        wdata[1] = bus.f_wdata;
        wdata[2] = bus.e_wdata;
        wdata[3] = bus.d_wdata;
    end

    // While locked only the holder is considered, unless it releases or the watchdog fires.
    always_comb begin
        forced   = (state == LOCKED) && (lock_cnt == LIMIT8);
        hold_bus = (state == LOCKED) && !forced && (req[owner_q] || lock[owner_q]);
        winner   = 2'd0;
        if (hold_bus) begin
            winner = req[owner_q] ? owner_q : 2'd0;
        end else if (req[3]) begin
            winner = 2'd3;
        end else if (req[2]) begin
            winner = 2'd2;
        end else if (req[1]) begin
            winner = 2'd1;
        end
        gnt_next = 3'b000;
        if (winner != 2'd0) begin
            gnt_next[winner] = 1'b1;
        end
        cnt_inc = (lock_cnt == 8'hFF) ? lock_cnt : lock_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            owner_q     <= 2'd0;
            lock_cnt    <= 8'd0;
            gnt_q       <= 3'b000;
            rvalid_q    <= 3'b000;
            mem_en_q    <= 1'b0;
            mem_rw_n_q  <= 1'b1;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            lock_err_q  <= 1'b0;
        end else begin
            rvalid_q <= (mem_en_q && mem_rw_n_q) ? gnt_q : 3'b000;
            gnt_q    <= gnt_next;
            mem_en_q <= (winner != 2'd0);
            if (winner != 2'd0) begin
                mem_rw_n_q  <= rw_n[winner];
                mem_addr_q  <= addr[winner];
                mem_wdata_q <= wdata[winner];
            end else begin
                mem_rw_n_q  <= 1'b1;
            end
            if (forced) begin
                lock_err_q <= 1'b1;
            end
            // A lock request granted on a forced-release edge is not honoured.
            if (hold_bus && winner == 2'd0) begin
                state    <= LOCKED;
                lock_cnt <= cnt_inc;
            end else if (winner != 2'd0 && lock[winner] && !forced) begin
                state    <= LOCKED;
                owner_q  <= winner;
                lock_cnt <= hold_bus ? cnt_inc : 8'd0;
            end else if (winner != 2'd0) begin
                state    <= OPEN;
                owner_q  <= winner;
                lock_cnt <= 8'd0;
            end else begin
                state    <= IDLE;
                owner_q  <= 2'd0;
                lock_cnt <= 8'd0;
            end
        end
    end

    assign bus.f_gnt     = gnt_q[1];
    assign bus.e_gnt     = gnt_q[2];
    assign bus.d_gnt     = gnt_q[3];
    assign bus.f_rvalid  = rvalid_q[1];
    assign bus.e_rvalid  = rvalid_q[2];
    assign bus.d_rvalid  = rvalid_q[3];
    assign bus.rdata     = bus.mem_rdata;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_rw_n  = mem_rw_n_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.owner     = owner_q;
    assign bus.lock_err  = lock_err_q;

endmodule
